// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM frame demodulator.
package ppm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam int SYNC = 2;

    function automatic int frame_len(input int n, input int slot_cycles);
        return (1 << n) * slot_cycles;
    endfunction

endpackage

// File: rtl/ppm_sync_edge.sv
// Three-flop synchroniser for the asynchronous PPM line with rising-edge detect.
module ppm_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ppm,
    output logic o_edge
);

    logic s1, s2, s3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_ppm;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign o_edge = s2 & ~s3;

endmodule

// File: rtl/ppm_demod_frame.sv
// PPM symbol demodulator: decodes one 2^N-slot frame per start, result via valid/ready.
// state | meaning
// IDLE  | waiting for i_start
// RUN   | SYNC pre-frame cycles, then F frame cycles of edge capture
// HOLD  | result presented, waiting for i_ready
module ppm_demod_frame
    import ppm_pkg::*;
#(
    parameter int N           = 4,
    parameter int SLOT_CYCLES = 4,
    parameter bit SIGNED_OUT  = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ppm,
    input  logic         i_start,
    output logic         o_busy,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_data,
    output logic         o_err_none,
    output logic         o_err_multi
);

    localparam int F  = frame_len(N, SLOT_CYCLES);
    localparam int PW = $clog2(F + SYNC + 1) + 1;
    localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [PW-1:0] POS_START = PW'(-SYNC);
    localparam logic [PW-1:0] POS_LAST  = PW'(F - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [N-1:0]  MSB_MASK  = N'(1 << (N - 1));

    state_t state, state_nxt;
    logic start_frame, end_frame;
    logic ppm_edge;
    logic signed [PW-1:0] pos;
    logic [CW-1:0] cyc;
    logic [N-1:0] slot, slot_q, slot_now;
    logic first_seen, multi;
    logic in_frame, last, hit, seen_now, multi_now;

    ppm_sync_edge u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_ppm  (i_ppm),
        .o_edge (ppm_edge)
    );

    // The final frame cycle is captured on the same edge that publishes the result,
    // so the result uses these look-ahead terms rather than the registers.
    assign in_frame  = ~pos[PW-1];
    assign last      = (pos == POS_LAST);
    assign hit       = (state == RUN) && in_frame && ppm_edge;
    assign seen_now  = first_seen | hit;
    assign multi_now = multi | (hit & first_seen);
    assign slot_now  = first_seen ? slot_q : slot;

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt   = RUN;
                    start_frame = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = HOLD;
                    end_frame = 1'b1;
                end
            end
            HOLD: begin
                if (i_ready) begin
                    if (i_start) begin
                        state_nxt   = RUN;
                        start_frame = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos        <= '0;
            cyc        <= '0;
            slot       <= '0;
            slot_q     <= '0;
            first_seen <= 1'b0;
            multi      <= 1'b0;
        end else if (start_frame) begin
            pos        <= POS_START;
            cyc        <= '0;
            slot       <= '0;
            first_seen <= 1'b0;
            multi      <= 1'b0;
        end else if (state == RUN) begin
            pos        <= pos + PW'(1);
            slot_q     <= slot_now;
            first_seen <= seen_now;
            multi      <= multi_now;
            if (in_frame && !last) begin
                if (cyc == CYC_LAST) begin
                    cyc  <= '0;
                    slot <= slot + N'(1);
                end else begin
                    cyc <= cyc + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data      <= '0;
            o_err_none  <= 1'b0;
            o_err_multi <= 1'b0;
        end else if (end_frame) begin
            o_err_none  <= ~seen_now;
            o_err_multi <= multi_now;
            if (!seen_now)       o_data <= '0;
            else if (SIGNED_OUT) o_data <= slot_now ^ MSB_MASK;
            else                 o_data <= slot_now;
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_valid = (state == HOLD);

endmodule

// File: tb/tb_ppm_demod_frame.sv
// Bench for ppm_demod_frame: unsigned and signed instances against a frame-level model.
module tb_ppm_demod_frame;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int F  = 64;

    logic clk = 1'b0;
    logic rst, ppm, start, ready;
    logic busy_u, valid_u, none_u, multi_u;
    logic busy_s, valid_s, none_s, multi_s;
    logic [N-1:0] data_u, data_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ppm_demod_frame #(.N(N), .SLOT_CYCLES(SC), .SIGNED_OUT(1'b0)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_ppm(ppm), .i_start(start),
        .o_busy(busy_u), .o_valid(valid_u), .i_ready(ready), .o_data(data_u),
        .o_err_none(none_u), .o_err_multi(multi_u)
    );

    ppm_demod_frame #(.N(N), .SLOT_CYCLES(SC), .SIGNED_OUT(1'b1)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_ppm(ppm), .i_start(start),
        .o_busy(busy_s), .o_valid(valid_s), .i_ready(ready), .o_data(data_s),
        .o_err_none(none_s), .o_err_multi(multi_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: line history per edge, results decoded by counting rising transitions.
    typedef enum {M_IDLE, M_RUN, M_HOLD} mmode_t;
    mmode_t mmode = M_IDLE;
    bit hist [0:8191];
    int edge_n = 0;
    int sedge  = 0;
    bit model_live = 1'b0;
    logic exp_busy = 1'b0, exp_valid = 1'b0, exp_none = 1'b0, exp_multi = 1'b0;
    logic [N-1:0] exp_udata = '0, exp_sdata = '0;

    always @(posedge clk) begin
        int first, cnt;
        hist[edge_n] = rst ? 1'b0 : ppm;
        if (rst) begin
            model_live = 1'b1;
            mmode      = M_IDLE;
            exp_valid  = 1'b0;
            exp_none   = 1'b0;
            exp_multi  = 1'b0;
            exp_udata  = '0;
            exp_sdata  = '0;
        end else begin
            case (mmode)
                M_IDLE: if (start) begin mmode = M_RUN; sedge = edge_n; end
                M_RUN: begin
                    if (edge_n == sedge + F + 2) begin
                        first = -1;
                        cnt   = 0;
                        for (int c = 0; c < F; c++) begin
                            if (hist[sedge + 1 + c] && !hist[sedge + c]) begin
                                cnt++;
                                if (first < 0) first = c / SC;
                            end
                        end
                        exp_none  = (cnt == 0);
                        exp_multi = (cnt > 1);
                        exp_udata = (cnt == 0) ? '0 : N'(first);
                        exp_sdata = (cnt == 0) ? '0 : N'(first - (1 << (N - 1)));
                        exp_valid = 1'b1;
                        mmode     = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (ready) begin
                        exp_valid = 1'b0;
                        if (start) begin mmode = M_RUN; sedge = edge_n; end
                        else       mmode = M_IDLE;
                    end
                end
                default: mmode = M_IDLE;
            endcase
        end
        exp_busy = (mmode != M_IDLE);
        edge_n++;
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("busy_u",  busy_u,  exp_busy);
            chk("valid_u", valid_u, exp_valid);
            chk("data_u",  data_u,  exp_udata);
            chk("none_u",  none_u,  exp_none);
            chk("multi_u", multi_u, exp_multi);
            chk("busy_s",  busy_s,  exp_busy);
            chk("valid_s", valid_s, exp_valid);
            chk("data_s",  data_s,  exp_sdata);
            chk("none_s",  none_s,  exp_none);
            chk("multi_s", multi_s, exp_multi);
        end
    end

    // c < 0 means no pulse; a pulse at frame cycle c is high at edges c+1 and c+2 after start.
    task automatic frame(input int c1, input int c2, input bit pre_high, input bit with_ready);
        start = 1'b1;
        ready = with_ready;
        ppm   = pre_high;
        @(negedge clk);
        start = 1'b0;
        ready = 1'b0;
        for (int j = 1; j <= F + 2; j++) begin
            ppm = pre_high | (c1 >= 0 && (j == c1 + 1 || j == c1 + 2))
                           | (c2 >= 0 && (j == c2 + 1 || j == c2 + 2));
            @(negedge clk);
        end
    endtask

    task automatic expect_res(input string name, input logic [3:0] du, input logic [3:0] ds,
                              input bit none, input bit multi);
        chk({name, "_valid"}, valid_u, 1'b1);
        chk({name, "_data_u"}, data_u, du);
        chk({name, "_data_s"}, data_s, ds);
        chk({name, "_none"}, none_u, none);
        chk({name, "_multi"}, multi_u, multi);
    endtask

    task automatic release_res(input string name);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk({name, "_rel_valid"}, valid_u, 1'b0);
        chk({name, "_rel_busy"}, busy_u, 1'b0);
    endtask

    initial begin
        rst = 1'b1; ppm = 1'b0; start = 1'b0; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ppm   = i[0];
            start = (i == 1);
            @(negedge clk);
        end
        chk("rst_busy", busy_u, 1'b0);
        chk("rst_valid", valid_u, 1'b0);
        chk("rst_data", data_u, 4'h0);
        rst = 1'b0; start = 1'b0; ppm = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst_start", busy_u, 1'b0);

        frame(21, -1, 1'b0, 1'b0);
        expect_res("single", 4'd5, 4'hD, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        expect_res("single_hold", 4'd5, 4'hD, 1'b0, 1'b0);
        release_res("single");

        frame(-1, -1, 1'b0, 1'b0);
        expect_res("none", 4'd0, 4'd0, 1'b1, 1'b0);
        release_res("none");

        frame(9, 37, 1'b0, 1'b0);
        expect_res("multi", 4'd2, 4'hA, 1'b0, 1'b1);
        release_res("multi");

        frame(-1, -1, 1'b1, 1'b0);
        expect_res("prehigh", 4'd0, 4'd0, 1'b1, 1'b0);
        release_res("prehigh");

        frame(0, -1, 1'b0, 1'b0);
        expect_res("slot0", 4'd0, 4'h8, 1'b0, 1'b0);
        frame(63, -1, 1'b0, 1'b1);
        expect_res("slot15_b2b", 4'd15, 4'h7, 1'b0, 1'b0);
        release_res("slot15_b2b");

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 1; j <= 32; j++) begin
            ppm = (j == 6 || j == 7);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy_u, 1'b0);
        chk("midrst_data", data_u, 4'h0);
        chk("midrst_data_s", data_s, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        frame(41, -1, 1'b0, 1'b0);
        expect_res("after_rst", 4'd10, 4'h2, 1'b0, 1'b0);
        release_res("after_rst");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
